hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Producer-side companion to the pipeline forwarding logic in the 5-stage RV32I core.
- Tracks destination-register tags through the EX, MEM and WB stages. Drives the EX/MEM and MEM/WB RegWrite/rd signals that the forwarding comparators consume.
- Generates all pipeline stall, bubble and flush controls:
  - load-use stall
  - taken-branch flush
  - data-memory wait hold

Parameters:
REG_ADDR_W, 5, register-index width
CNT_W, 16, width of optional performance counters

Ports:
clk  in  1  core clock
reset  in  1  synchronous active-high reset
id_valid  in  1  ID stage holds a real instruction
id_rs1  in  REG_ADDR_W  ID source register 1
id_rs2  in  REG_ADDR_W  ID source register 2
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_rd  in  REG_ADDR_W  ID destination register
id_regwrite  in  1  instruction writes rd
id_memread  in  1  instruction is a load
id_memwrite  in  1  instruction is a store
ex_branch_taken  in  1  branch/jump in EX resolved taken (level)
dmem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID register load enable
ifid_flush  out  1  IF/ID loads NOP
idex_bubble  out  1  ID/EX loads NOP
pipe_hold  out  1  freeze ID/EX and EX/MEM registers
memwb_bubble  out  1  MEM/WB loads NOP
exmem_regwrite  out  1  MEM-stage tag writes register (valid-gated)
exmem_rd  out  REG_ADDR_W  MEM-stage destination
memwb_regwrite  out  1  WB-stage tag writes register (valid-gated)
memwb_rd  out  REG_ADDR_W  WB-stage destination

Behaviour:
- Internal tag per stage (EX, MEM, WB): {valid, rd, regwrite, memread, memwrite}. All tags are registered and advance on clk.
- Reset:
  - Clears all tags to 0.
  - While reset is high, outputs are forced to: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, pipe_hold=0, memwb_bubble=1.
  - exmem_regwrite, memwb_regwrite and both rd outputs are 0 from the first post-reset edge.
- Combinational conditions:
  - hold = MEM.valid & (MEM.memread | MEM.memwrite) & !dmem_ready.
  - flush = EX.valid & ex_branch_taken.
  - lu = EX.valid & EX.memread & EX.rd!=0 & id_valid & ((id_use_rs1 & id_rs1==EX.rd) | (id_use_rs2 & id_rs2==EX.rd)).
- Priority: reset > hold > flush > lu > run.
- hold:
  - Outputs: pc_write=0, ifid_write=0, pipe_hold=1, memwb_bubble=1.
  - Tags: EX and MEM unchanged, WB←invalid.
  - flush and lu are ignored and re-evaluated once hold drops.
- flush:
  - Outputs: ifid_flush=1, idex_bubble=1, pc_write=1.
  - Tags: EX←invalid, MEM←EX, WB←MEM.
  - Kills exactly the two younger instructions.
- lu:
  - Outputs: pc_write=0, ifid_write=0, idex_bubble=1.
  - Tags: EX←invalid, MEM←EX, WB←MEM.
  - Exactly one bubble; the next cycle sees the load in MEM, so no hazard.
- run:
  - Outputs: all enables high, no bubbles.
  - Tags: EX←{id_valid, id_rd, id_regwrite, id_memread, id_memwrite}, MEM←EX, WB←MEM.
- Output gating:
  - exmem_regwrite = MEM.valid & MEM.regwrite & MEM.rd!=0; memwb_regwrite likewise for WB.
  - The rd outputs show the tag rd regardless of valid.
- Store with rd field: no regwrite tag. Loads to x0 never stall.
- Reset asserted mid-hold or mid-stall: all state is discarded next edge; no pending stall survives.
- Hold of N cycles inserts N WB bubbles; the load writes back exactly once, after release.

Optional Feature:
HAZARD_PERF_EN
- Defined:
  - Adds outputs lu_stall_cnt, flush_cnt and hold_cnt, each CNT_W wide.
  - Counters count cycles with lu, flush and hold asserted respectively, under the same priority as above.
  - Each counter saturates at all-ones and clears on reset.
- Undefined: ports and counters are absent; core behaviour is identical.

Decomposition:
- Shared package holds:
  - REG_ADDR_W
  - the stage-tag struct/field widths
  - NOP encoding constant 32'h00000013
- One natural sub-module: hazard_tag_stage, a single tag register with load/hold/clear controls, instantiated three times.

Test Plan:
- Load-use: EX=lw x5, ID=add x6,x5,x1 (use_rs1) → one cycle with pc_write=0, ifid_write=0, idex_bubble=1; next cycle run; two cycles later memwb_rd=5, memwb_regwrite=1.
- Load to x0: EX=lw x0, ID reads x0 → no stall; exmem_regwrite=0 the next cycle.
- Branch taken in EX with a load-use also present → ifid_flush=1, idex_bubble=1, pc_write=1; EX tag invalid next cycle.
- Hold: MEM=lw x7, dmem_ready low 3 cycles → pipe_hold=1 for 3 cycles, memwb_regwrite=0 throughout; memwb_rd=7 with regwrite=1 exactly once after release.
- Reset asserted during hold cycle 2 → next cycle all tags invalid; exmem_regwrite=0, memwb_regwrite=0; pc_write=1 after reset drops.
- Back-to-back add x1; add x2 → exmem_rd/memwb_rd sequence 1 then 2 with regwrite=1 and no stalls.

Source files
------------

// File: rtl/hazard_control_unit_pkg.sv
// Shared types and constants for the hazard control unit: stage tag layout,
// priority-decoded pipeline mode and the canonical NOP encoding.
package hazard_control_unit_pkg;

  localparam int REG_ADDR_W = 5;

  // addi x0, x0, 0 -- what IF/ID and ID/EX load when they are bubbled
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
    logic                  memwrite;
  } stage_tag_t;

  localparam int TAG_W = $bits(stage_tag_t);

  // One mode per cycle, already resolved by priority reset > hold > flush > lu > run
  typedef enum logic [2:0] {
    MODE_RUN   = 3'd0,
    MODE_LU    = 3'd1,
    MODE_FLUSH = 3'd2,
    MODE_HOLD  = 3'd3,
    MODE_RESET = 3'd4
  } hazard_mode_e;

endpackage

// File: rtl/hazard_control_unit_tag_stage.sv
// One pipeline-stage tag register. Clear wins over load; neither keeps the value.
module hazard_tag_stage
  import hazard_control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  stage_tag_t d,
  output stage_tag_t q
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Producer-side hazard control: tracks EX/MEM/WB destination tags and drives
// stall, bubble, flush and hold controls. HAZARD_PERF_EN adds event counters.
module hazard_control_unit #(
  parameter int REG_ADDR_W = hazard_control_unit_pkg::REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  id_memwrite,
  input  logic                  ex_branch_taken,
  input  logic                  dmem_ready,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  pipe_hold,
  output logic                  memwb_bubble,
  output logic                  exmem_regwrite,
  output logic [REG_ADDR_W-1:0] exmem_rd,
  output logic                  memwb_regwrite,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0]      lu_stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      hold_cnt,
`endif
  output logic [REG_ADDR_W-1:0] memwb_rd
);

  import hazard_control_unit_pkg::*;

  stage_tag_t   id_tag, ex_tag, mem_tag, wb_tag;
  hazard_mode_e mode;
  logic         hold, flush, lu;
  logic         ex_clear, ex_load, mem_load, wb_clear, wb_load;

  // A store's rd field is really imm bits, so it never produces a write tag
  always_comb begin
    id_tag          = '0;
    id_tag.valid    = id_valid;
    id_tag.rd       = id_rd;
    id_tag.regwrite = id_regwrite & ~id_memwrite;
    id_tag.memread  = id_memread;
    id_tag.memwrite = id_memwrite;
  end

  always_comb begin
    hold  = mem_tag.valid & (mem_tag.memread | mem_tag.memwrite) & ~dmem_ready;
    flush = ex_tag.valid & ex_branch_taken;
    lu    = ex_tag.valid & ex_tag.memread & (ex_tag.rd != '0) & id_valid &
            ((id_use_rs1 & (id_rs1 == ex_tag.rd)) |
             (id_use_rs2 & (id_rs2 == ex_tag.rd)));
  end

  always_comb begin
    mode = MODE_RUN;
    if (reset)      mode = MODE_RESET;
    else if (hold)  mode = MODE_HOLD;
    else if (flush) mode = MODE_FLUSH;
    else if (lu)    mode = MODE_LU;
  end

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    pipe_hold    = 1'b0;
    memwb_bubble = 1'b0;
    ex_clear     = 1'b0;
    ex_load      = 1'b1;
    mem_load     = 1'b1;
    wb_clear     = 1'b0;
    wb_load      = 1'b1;
    case (mode)
      MODE_RESET: begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        ifid_flush   = 1'b1;
        idex_bubble  = 1'b1;
        memwb_bubble = 1'b1;
      end
      // Freeze EX and MEM while the memory access completes; WB sees bubbles
      MODE_HOLD: begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        pipe_hold    = 1'b1;
        memwb_bubble = 1'b1;
        ex_load      = 1'b0;
        mem_load     = 1'b0;
        wb_clear     = 1'b1;
      end
      MODE_FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        ex_clear    = 1'b1;
      end
      MODE_LU: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        ex_clear    = 1'b1;
      end
      default: ;
    endcase
  end

  hazard_tag_stage u_ex_tag (
    .clk   (clk),
    .reset (reset),
    .clear (ex_clear),
    .load  (ex_load),
    .d     (id_tag),
    .q     (ex_tag)
  );

  hazard_tag_stage u_mem_tag (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .load  (mem_load),
    .d     (ex_tag),
    .q     (mem_tag)
  );

  hazard_tag_stage u_wb_tag (
    .clk   (clk),
    .reset (reset),
    .clear (wb_clear),
    .load  (wb_load),
    .d     (mem_tag),
    .q     (wb_tag)
  );

  // x0 writes are dropped here so the forwarding comparators never match x0
  assign exmem_regwrite = mem_tag.valid & mem_tag.regwrite & (mem_tag.rd != '0);
  assign exmem_rd       = mem_tag.rd;
  assign memwb_regwrite = wb_tag.valid & wb_tag.regwrite & (wb_tag.rd != '0);
  assign memwb_rd       = wb_tag.rd;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      lu_stall_cnt <= '0;
      flush_cnt    <= '0;
      hold_cnt     <= '0;
    end else begin
      if (mode == MODE_LU && lu_stall_cnt != '1)
        lu_stall_cnt <= lu_stall_cnt + CNT_W'(1);
      if (mode == MODE_FLUSH && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
      if (mode == MODE_HOLD && hold_cnt != '1)
        hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: reset, load-use, x0 load, flush,
// memory hold, reset during hold and back-to-back ALU ops.
module tb_hazard_control_unit;

  localparam int RW = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_use_rs1, id_use_rs2;
  logic          id_regwrite, id_memread, id_memwrite;
  logic          ex_branch_taken, dmem_ready;
  logic          pc_write, ifid_write, ifid_flush, idex_bubble;
  logic          pipe_hold, memwb_bubble;
  logic          exmem_regwrite, memwb_regwrite;
  logic [RW-1:0] exmem_rd, memwb_rd;
`ifdef HAZARD_PERF_EN
  logic [CW-1:0] lu_stall_cnt, flush_cnt, hold_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .id_rd           (id_rd),
    .id_regwrite     (id_regwrite),
    .id_memread      (id_memread),
    .id_memwrite     (id_memwrite),
    .ex_branch_taken (ex_branch_taken),
    .dmem_ready      (dmem_ready),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .pipe_hold       (pipe_hold),
    .memwb_bubble    (memwb_bubble),
    .exmem_regwrite  (exmem_regwrite),
    .exmem_rd        (exmem_rd),
    .memwb_regwrite  (memwb_regwrite),
`ifdef HAZARD_PERF_EN
    .lu_stall_cnt    (lu_stall_cnt),
    .flush_cnt       (flush_cnt),
    .hold_cnt        (hold_cnt),
`endif
    .memwb_rd        (memwb_rd)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_none();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0;
    id_regwrite = 0; id_memread = 0; id_memwrite = 0;
  endtask

  task automatic id_instr(input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                          input logic [RW-1:0] rs2, input logic u1, input logic u2,
                          input logic rw, input logic mr, input logic mw);
    id_valid = 1; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2;
    id_regwrite = rw; id_memread = mr; id_memwrite = mw;
  endtask

  task automatic drain();
    id_none();
    repeat (3) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc_write"},     8'(pc_write),     8'd0);
    check({tag, "_ifid_write"},   8'(ifid_write),   8'd0);
    check({tag, "_ifid_flush"},   8'(ifid_flush),   8'd1);
    check({tag, "_idex_bubble"},  8'(idex_bubble),  8'd1);
    check({tag, "_pipe_hold"},    8'(pipe_hold),    8'd0);
    check({tag, "_memwb_bubble"}, 8'(memwb_bubble), 8'd1);
  endtask

  initial begin
    reset = 1; ex_branch_taken = 0; dmem_ready = 1;
    id_none();
    #1;
    step(); step();

    // reset state
    check_reset_outputs("rst");
    check("rst_exmem_regwrite", 8'(exmem_regwrite), 8'd0);
    check("rst_memwb_regwrite", 8'(memwb_regwrite), 8'd0);
    check("rst_exmem_rd", 8'(exmem_rd), 8'd0);
    check("rst_memwb_rd", 8'(memwb_rd), 8'd0);
    reset = 0;
    #1;
    check("post_rst_pc_write", 8'(pc_write), 8'd1);
    check("post_rst_idex_bubble", 8'(idex_bubble), 8'd0);

    // load-use: lw x5 in EX, add x6,x5,x1 in ID
    id_instr(5'd5, 5'd1, 5'd0, 1, 0, 1, 1, 0);
    step();
    id_instr(5'd6, 5'd5, 5'd1, 1, 1, 1, 0, 0);
    #1;
    check("lu_pc_write", 8'(pc_write), 8'd0);
    check("lu_ifid_write", 8'(ifid_write), 8'd0);
    check("lu_idex_bubble", 8'(idex_bubble), 8'd1);
    check("lu_ifid_flush", 8'(ifid_flush), 8'd0);
    step();
    check("lu_next_pc_write", 8'(pc_write), 8'd1);
    check("lu_next_idex_bubble", 8'(idex_bubble), 8'd0);
    check("lu_exmem_rd", 8'(exmem_rd), 8'd5);
    check("lu_exmem_regwrite", 8'(exmem_regwrite), 8'd1);
    step();
    check("lu_memwb_rd", 8'(memwb_rd), 8'd5);
    check("lu_memwb_regwrite", 8'(memwb_regwrite), 8'd1);
    drain();

    // load to x0 never stalls and never produces a write tag
    id_instr(5'd0, 5'd2, 5'd0, 1, 0, 1, 1, 0);
    step();
    id_instr(5'd3, 5'd0, 5'd0, 1, 0, 1, 0, 0);
    #1;
    check("x0_pc_write", 8'(pc_write), 8'd1);
    check("x0_idex_bubble", 8'(idex_bubble), 8'd0);
    step();
    check("x0_exmem_regwrite", 8'(exmem_regwrite), 8'd0);
    drain();

    // taken branch in EX wins over a simultaneous load-use
    id_instr(5'd8, 5'd1, 5'd0, 1, 0, 1, 1, 0);
    step();
    id_instr(5'd9, 5'd0, 5'd8, 0, 1, 1, 0, 0);
    ex_branch_taken = 1;
    #1;
    check("fl_ifid_flush", 8'(ifid_flush), 8'd1);
    check("fl_idex_bubble", 8'(idex_bubble), 8'd1);
    check("fl_pc_write", 8'(pc_write), 8'd1);
    step();
    ex_branch_taken = 0;
    id_none();
    #1;
    check("fl_exmem_rd", 8'(exmem_rd), 8'd8);
    check("fl_idle_ifid_flush", 8'(ifid_flush), 8'd0);
    step();
    check("fl_ex_killed", 8'(exmem_regwrite), 8'd0);
    drain();

    // data-memory hold: lw x7 waits three cycles in MEM
    id_instr(5'd7, 5'd1, 5'd0, 1, 0, 1, 1, 0);
    step();
    id_none();
    step();
    dmem_ready = 0;
    for (int i = 1; i <= 3; i++) begin
      #1;
      check($sformatf("hold%0d_pipe_hold", i), 8'(pipe_hold), 8'd1);
      check($sformatf("hold%0d_pc_write", i), 8'(pc_write), 8'd0);
      check($sformatf("hold%0d_memwb_bubble", i), 8'(memwb_bubble), 8'd1);
      check($sformatf("hold%0d_memwb_regwrite", i), 8'(memwb_regwrite), 8'd0);
      check($sformatf("hold%0d_exmem_rd", i), 8'(exmem_rd), 8'd7);
      if (i < 3) step();
    end
    dmem_ready = 1;
    #1;
    check("hold_rel_pipe_hold", 8'(pipe_hold), 8'd0);
    check("hold_rel_pc_write", 8'(pc_write), 8'd1);
    step();
    check("hold_wb_rd", 8'(memwb_rd), 8'd7);
    check("hold_wb_regwrite", 8'(memwb_regwrite), 8'd1);
    step();
    check("hold_wb_once", 8'(memwb_regwrite), 8'd0);
    drain();

    // reset during hold cycle 2 discards everything
    id_instr(5'd4, 5'd1, 5'd0, 1, 0, 1, 1, 0);
    step();
    id_none();
    step();
    dmem_ready = 0;
    #1;
    check("rh1_pipe_hold", 8'(pipe_hold), 8'd1);
    step();
    reset = 1;
    #1;
    check_reset_outputs("rh2");
    step();
    reset = 0;
    #1;
    check("rh_pipe_hold", 8'(pipe_hold), 8'd0);
    check("rh_pc_write", 8'(pc_write), 8'd1);
    check("rh_exmem_regwrite", 8'(exmem_regwrite), 8'd0);
    check("rh_memwb_regwrite", 8'(memwb_regwrite), 8'd0);
    check("rh_exmem_rd", 8'(exmem_rd), 8'd0);
    dmem_ready = 1;
    drain();

    // back-to-back add x1; add x2
    id_instr(5'd1, 5'd3, 5'd4, 1, 1, 1, 0, 0);
    step();
    id_instr(5'd2, 5'd3, 5'd4, 1, 1, 1, 0, 0);
    #1;
    check("b2b_pc_write", 8'(pc_write), 8'd1);
    step();
    id_none();
    #1;
    check("b2b_exmem_rd_1", 8'(exmem_rd), 8'd1);
    check("b2b_exmem_rw_1", 8'(exmem_regwrite), 8'd1);
    step();
    check("b2b_exmem_rd_2", 8'(exmem_rd), 8'd2);
    check("b2b_exmem_rw_2", 8'(exmem_regwrite), 8'd1);
    check("b2b_memwb_rd_1", 8'(memwb_rd), 8'd1);
    check("b2b_memwb_rw_1", 8'(memwb_regwrite), 8'd1);
    step();
    check("b2b_memwb_rd_2", 8'(memwb_rd), 8'd2);
    check("b2b_memwb_rw_2", 8'(memwb_regwrite), 8'd1);

    // a store's rd field never becomes a write tag
    id_instr(5'd10, 5'd1, 5'd2, 1, 1, 1, 0, 1);
    step();
    id_none();
    step();
    check("st_exmem_regwrite", 8'(exmem_regwrite), 8'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
